// File: rtl/core_acc_quant.sv
// -----------------------------------------------------------------------------
// core_acc_quant
// Post-MAC accumulate-and-requantize stage. Sums cfg_acc_num consecutive
// signed MAC partial sums, applies (acc * scale + bias), then shifts
// arithmetically, rounds half-up and saturates to a signed IDATA_WIDTH result.
//
// Pipeline: S0 accumulate -> S1 scale/bias -> S2 shift/round/saturate -> out.
// A group's final beat sampled on edge N produces quant_odata_valid in the
// cycle after edge N+2.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_vld            load cfg_* fields; aborts any open partial group and
//                      drops a coincident MAC beat
//   cfg_acc_num        beats per group (0 behaves as 1)
//   cfg_quant_scale    signed multiplier
//   cfg_quant_bias     signed additive bias
//   cfg_quant_shift    right-shift amount, 0..31
//   mac_odata          signed MAC partial sum
//   mac_odata_valid    mac_odata qualifier
//   quant_odata        requantized result, held while valid is low
//   quant_odata_valid  one-cycle pulse per completed group
//   busy               partial group open or any pipeline stage occupied
// -----------------------------------------------------------------------------
module core_acc_quant #(
  parameter int IDATA_WIDTH          = 8,
  parameter int ODATA_BIT            = 25,
  parameter int ACC_WIDTH            = 32,
  parameter int CDATA_ACCU_NUM_WIDTH = 10,
  parameter int CDATA_SCALE_WIDTH    = 10,
  parameter int CDATA_BIAS_WIDTH     = 16,
  parameter int CDATA_SHIFT_WIDTH    = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_vld,
  input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
  input  logic [CDATA_SCALE_WIDTH-1:0]    cfg_quant_scale,
  input  logic [CDATA_BIAS_WIDTH-1:0]     cfg_quant_bias,
  input  logic [CDATA_SHIFT_WIDTH-1:0]    cfg_quant_shift,
  input  logic [ODATA_BIT-1:0]            mac_odata,
  input  logic                            mac_odata_valid,
  output logic [IDATA_WIDTH-1:0]          quant_odata,
  output logic                            quant_odata_valid,
  output logic                            busy
);

  // Full-precision width of acc * scale + bias.
  localparam int PW = ACC_WIDTH + CDATA_SCALE_WIDTH + 1;
  localparam logic signed [PW-1:0] QMAX = (PW'(1) <<< (IDATA_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] QMIN = -QMAX - PW'(1);

  // Cfg registers
  logic [CDATA_ACCU_NUM_WIDTH-1:0] acc_num_reg;
  logic [CDATA_SCALE_WIDTH-1:0]    scale_reg;
  logic [CDATA_BIAS_WIDTH-1:0]     bias_reg;
  logic [CDATA_SHIFT_WIDTH-1:0]    shift_reg;

  // S0 state
  logic [ACC_WIDTH-1:0]            acc_reg;
  logic [CDATA_ACCU_NUM_WIDTH-1:0] acc_cnt_reg;

  // S1 state (sum plus cfg snapshot)
  logic                            s1_vld_reg;
  logic [ACC_WIDTH-1:0]            s1_acc_reg;
  logic [CDATA_SCALE_WIDTH-1:0]    s1_scale_reg;
  logic [CDATA_BIAS_WIDTH-1:0]     s1_bias_reg;
  logic [CDATA_SHIFT_WIDTH-1:0]    s1_shift_reg;

  // S2 state
  logic                            s2_vld_reg;
  logic signed [PW-1:0]            s2_val_reg;
  logic [CDATA_SHIFT_WIDTH-1:0]    s2_shift_reg;

  // Output registers
  logic [IDATA_WIDTH-1:0]          quant_odata_reg;
  logic                            quant_valid_reg;

  // ---------------------------------------------------------------------------
  // S0 combinational helpers
  // ---------------------------------------------------------------------------
  logic [CDATA_ACCU_NUM_WIDTH-1:0] last_idx;
  logic [ACC_WIDTH-1:0]            acc_sum;
  logic                            last_beat;

  // acc_num of 0 is treated as 1, so its last index is 0 as well.
  assign last_idx  = (acc_num_reg == '0) ? '0
                   : acc_num_reg - CDATA_ACCU_NUM_WIDTH'(1);
  assign acc_sum   = acc_reg + {{(ACC_WIDTH-ODATA_BIT){mac_odata[ODATA_BIT-1]}}, mac_odata};
  assign last_beat = (acc_cnt_reg == last_idx);

  // ---------------------------------------------------------------------------
  // S1 combinational: sign-extend operands to full precision. The true product
  // fits in PW bits, so the PW-wide multiply is exact.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] s1_acc_ext;
  logic signed [PW-1:0] s1_scale_ext;
  logic signed [PW-1:0] s1_bias_ext;
  logic signed [PW-1:0] s1_result;

  assign s1_acc_ext   = {{(PW-ACC_WIDTH){s1_acc_reg[ACC_WIDTH-1]}}, s1_acc_reg};
  assign s1_scale_ext = {{(PW-CDATA_SCALE_WIDTH){s1_scale_reg[CDATA_SCALE_WIDTH-1]}}, s1_scale_reg};
  assign s1_bias_ext  = {{(PW-CDATA_BIAS_WIDTH){s1_bias_reg[CDATA_BIAS_WIDTH-1]}}, s1_bias_reg};
  assign s1_result    = s1_acc_ext * s1_scale_ext + s1_bias_ext;

  // ---------------------------------------------------------------------------
  // S2 combinational: shift, round half-up, saturate
  // ---------------------------------------------------------------------------
  logic [CDATA_SHIFT_WIDTH-1:0] shift_m1;
  logic [PW-1:0]                rnd_mask;
  logic                         rnd;
  logic signed [PW-1:0]         rnd_ext;
  logic signed [PW-1:0]         shifted;
  logic signed [PW-1:0]         rounded;
  logic [IDATA_WIDTH-1:0]       sat_val;

  always_comb begin
    shift_m1 = s2_shift_reg - CDATA_SHIFT_WIDTH'(1);
    rnd_mask = {{(PW-1){1'b0}}, 1'b1} << shift_m1;
    // Round bit is the most significant discarded bit; none when shift is 0.
    rnd      = (s2_shift_reg != '0) && (|(s2_val_reg & rnd_mask));
    rnd_ext  = {{(PW-1){1'b0}}, rnd};
    shifted  = s2_val_reg >>> s2_shift_reg;
    rounded  = shifted + rnd_ext;
    if (rounded > QMAX) begin
      sat_val = QMAX[IDATA_WIDTH-1:0];
    end else if (rounded < QMIN) begin
      sat_val = QMIN[IDATA_WIDTH-1:0];
    end else begin
      sat_val = rounded[IDATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Cfg load and S0 accumulate
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_num_reg  <= CDATA_ACCU_NUM_WIDTH'(1);
      scale_reg    <= CDATA_SCALE_WIDTH'(1);
      bias_reg     <= '0;
      shift_reg    <= '0;
      acc_reg      <= '0;
      acc_cnt_reg  <= '0;
      s1_vld_reg   <= 1'b0;
      s1_acc_reg   <= '0;
      s1_scale_reg <= '0;
      s1_bias_reg  <= '0;
      s1_shift_reg <= '0;
    end else begin
      s1_vld_reg <= 1'b0;
      if (cfg_vld) begin
        // New cfg aborts the open group; a coincident beat is dropped.
        acc_num_reg <= cfg_acc_num;
        scale_reg   <= cfg_quant_scale;
        bias_reg    <= cfg_quant_bias;
        shift_reg   <= cfg_quant_shift;
        acc_reg     <= '0;
        acc_cnt_reg <= '0;
      end else if (mac_odata_valid) begin
        if (last_beat) begin
          s1_vld_reg   <= 1'b1;
          s1_acc_reg   <= acc_sum;
          s1_scale_reg <= scale_reg;
          s1_bias_reg  <= bias_reg;
          s1_shift_reg <= shift_reg;
          acc_reg      <= '0;
          acc_cnt_reg  <= '0;
        end else begin
          acc_reg     <= acc_sum;
          acc_cnt_reg <= acc_cnt_reg + CDATA_ACCU_NUM_WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1 -> S2 and S2 -> output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_reg      <= 1'b0;
      s2_val_reg      <= '0;
      s2_shift_reg    <= '0;
      quant_valid_reg <= 1'b0;
      quant_odata_reg <= '0;
    end else begin
      s2_vld_reg      <= s1_vld_reg;
      quant_valid_reg <= s2_vld_reg;
      if (s1_vld_reg) begin
        s2_val_reg   <= s1_result;
        s2_shift_reg <= s1_shift_reg;
      end
      if (s2_vld_reg) begin
        quant_odata_reg <= sat_val;
      end
    end
  end

  assign quant_odata       = quant_odata_reg;
  assign quant_odata_valid = quant_valid_reg;
  assign busy = (acc_cnt_reg != '0) | s1_vld_reg | s2_vld_reg | quant_valid_reg;

endmodule

// File: tb/tb_core_acc_quant.sv
// -----------------------------------------------------------------------------
// tb_core_acc_quant
// Directed bench for core_acc_quant. Stimulus tasks push the hand-computed
// result and its expected arrival cycle into a queue; a monitor pops and
// compares on every quant_odata_valid pulse. Any pulse with an empty queue is
// reported as an unexpected output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_acc_quant;

  logic        clk;
  logic        rst;
  logic        cfg_vld;
  logic [9:0]  cfg_acc_num;
  logic [9:0]  cfg_quant_scale;
  logic [15:0] cfg_quant_bias;
  logic [4:0]  cfg_quant_shift;
  logic [24:0] mac_odata;
  logic        mac_odata_valid;
  logic [7:0]  quant_odata;
  logic        quant_odata_valid;
  logic        busy;

  core_acc_quant dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_vld           (cfg_vld),
    .cfg_acc_num       (cfg_acc_num),
    .cfg_quant_scale   (cfg_quant_scale),
    .cfg_quant_bias    (cfg_quant_bias),
    .cfg_quant_shift   (cfg_quant_shift),
    .mac_odata         (mac_odata),
    .mac_odata_valid   (mac_odata_valid),
    .quant_odata       (quant_odata),
    .quant_odata_valid (quant_odata_valid),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per observed output transaction.
  always @(negedge clk) begin
    if (!rst && quant_odata_valid) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse: got %0d at cycle %0d, required no pulse",
                 $signed(quant_odata), cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ($signed(quant_odata) != e.val || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL result: got %0d at cycle %0d, required %0d at cycle %0d",
                   $signed(quant_odata), cyc, e.val, e.cyc);
        end else begin
          $display("ok result %0d at cycle %0d", e.val, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks = checks + 1;
    if (got != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("ok %s = %0d", name, got);
    end
  endtask

  // One MAC beat; if last, the expected result is due 2 edges later.
  task automatic beat(input int d, input bit last, input int exp_val);
    exp_t e;
    @(negedge clk);
    cfg_vld         = 1'b0;
    mac_odata       = 25'(d);
    mac_odata_valid = 1'b1;
    @(posedge clk);
    #1;
    if (last) begin
      e.val = exp_val;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_vld         = 1'b0;
      mac_odata_valid = 1'b0;
    end
  endtask

  // Cfg load; optionally drives a beat in the same cycle (to be dropped).
  task automatic load_cfg(input int an, input int sc, input int bi, input int sh,
                          input bit with_beat, input int d);
    @(negedge clk);
    cfg_vld         = 1'b1;
    cfg_acc_num     = 10'(an);
    cfg_quant_scale = 10'(sc);
    cfg_quant_bias  = 16'(bi);
    cfg_quant_shift = 5'(sh);
    mac_odata       = 25'(d);
    mac_odata_valid = with_beat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    cfg_vld = 1'b0;
    cfg_acc_num = '0;
    cfg_quant_scale = '0;
    cfg_quant_bias = '0;
    cfg_quant_shift = '0;
    mac_odata = '0;
    mac_odata_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quant_odata", int'(quant_odata), 0);
    check("reset_valid", int'(quant_odata_valid), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset cfg: acc_num=1, scale=1, bias=0, shift=0 -> pass-through.
    beat(5, 1'b1, 5);
    idle(5);

    // Saturate high: 32 x 4096 = 131072, >>9 = 256 -> 127.
    load_cfg(32, 1, 0, 9, 1'b0, 0);
    for (int i = 1; i <= 32; i++) beat(4096, i == 32, 127);
    idle(5);

    // Round half-up, shift 9.
    load_cfg(4, 1, 0, 9, 1'b0, 0);
    for (int i = 1; i <= 4; i++) beat(75, i == 4, 1);
    for (int i = 1; i <= 4; i++) beat(-75, i == 4, -1);
    for (int i = 1; i <= 4; i++) beat(-32768, i == 4, -128);
    idle(5);

    // Scale and bias, shift 2: 30 -> 8, 28 -> 7.
    load_cfg(1, 3, 0, 2, 1'b0, 0);
    beat(10, 1'b1, 8);
    load_cfg(1, 3, -2, 2, 1'b0, 0);
    beat(10, 1'b1, 7);
    idle(5);

    // acc_num=0 acts as 1; 7*-2+5 = -9, >>>1 = -5, round bit 1 -> -4.
    load_cfg(0, -2, 5, 1, 1'b0, 0);
    beat(7, 1'b1, -4);
    idle(5);

    // Input gaps: 2 + 3 + 4 = 9; busy while group is open.
    load_cfg(3, 1, 0, 0, 1'b0, 0);
    beat(2, 1'b0, 0);
    check("busy_partial_group", int'(busy), 1);
    idle(1);
    beat(3, 1'b0, 0);
    idle(2);
    beat(4, 1'b1, 9);
    idle(5);

    // Setting isolation: new scale right after completion does not affect it.
    load_cfg(1, 1, 0, 0, 1'b0, 0);
    beat(9, 1'b1, 9);
    load_cfg(1, 5, 0, 0, 1'b0, 0);
    beat(2, 1'b1, 10);
    idle(5);

    // Back-to-back: 1..20, one result per cycle.
    load_cfg(1, 1, 0, 0, 1'b0, 0);
    for (int i = 1; i <= 20; i++) beat(i, 1'b1, i);
    idle(5);

    // Cfg abort: 5 beats lost, coincident beat dropped, then 3+4 = 7.
    load_cfg(8, 1, 0, 0, 1'b0, 0);
    for (int i = 1; i <= 5; i++) beat(10, 1'b0, 0);
    load_cfg(2, 1, 0, 0, 1'b1, 100);
    beat(3, 1'b0, 0);
    beat(4, 1'b1, 7);
    idle(6);

    // Reset mid-flight: no pulse for the interrupted group, busy drops at once.
    load_cfg(1, 1, 0, 0, 1'b0, 0);
    beat(50, 1'b0, 0);
    @(negedge clk);
    mac_odata_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("busy_after_rst", int'(busy), 0);
    check("valid_after_rst", int'(quant_odata_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Drain with a bound, then confirm nothing is still outstanding.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    idle(3);
    check("pending_expected", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_acc_quant.md
# core_acc_quant

Post-MAC accumulate-and-requantize stage inside `core_top`, placed directly downstream of the MAC multiplier tree. It sums `cfg_acc_num` consecutive signed MAC partial sums, then applies `(acc * scale + bias)`. The result is arithmetically shifted, rounded half-up, saturated to signed `IDATA_WIDTH`, and emitted as `quant_odata` with a one-cycle valid. This output feeds the core write-back path toward `out_gbus` and the hlink/vlink ports.

## Interface
Parameters:
- `IDATA_WIDTH`, 8: output element width (signed).
- `ODATA_BIT`, 25: MAC partial-sum width (signed).
- `ACC_WIDTH`, 32: accumulator width (signed).
- `CDATA_ACCU_NUM_WIDTH`, 10: width of `cfg_acc_num`.
- `CDATA_SCALE_WIDTH`, 10: width of `cfg_quant_scale` (signed).
- `CDATA_BIAS_WIDTH`, 16: width of `cfg_quant_bias` (signed).
- `CDATA_SHIFT_WIDTH`, 5: width of `cfg_quant_shift` (unsigned).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-high.
- `cfg_vld` in 1: load the four cfg fields below.
- `cfg_acc_num` in CDATA_ACCU_NUM_WIDTH: beats per group; 0 is treated as 1.
- `cfg_quant_scale` in CDATA_SCALE_WIDTH: signed multiplier.
- `cfg_quant_bias` in CDATA_BIAS_WIDTH: signed additive bias.
- `cfg_quant_shift` in CDATA_SHIFT_WIDTH: right-shift amount, 0..31.
- `mac_odata` in ODATA_BIT: signed MAC partial sum.
- `mac_odata_valid` in 1: `mac_odata` is valid this cycle.
- `quant_odata` out IDATA_WIDTH: requantized result.
- `quant_odata_valid` out 1: one-cycle pulse per completed group.
- `busy` out 1: a partial group is open or a pipeline stage is occupied.

## Operation
- **Config registers:** `cfg_vld` loads the config registers on the next edge. It also discards any open partial group: `acc_cnt` and `acc` are cleared. A `mac_odata_valid` beat in the same cycle as `cfg_vld` is dropped.
- **S0, accumulate:** on each valid beat, `acc <= acc + sext(mac_odata)` and `acc_cnt` increments.
  - On the beat where `acc_cnt == acc_num-1`, the final sum goes to `s1_acc` together with snapshots of scale, bias and shift.
  - `acc` and `acc_cnt` reset to 0 on that same edge, so the next group can start on the following beat.
  - Accumulator overflow wraps (two's complement) and is not flagged.
- **S1, scale/bias:** `s2_val <= s1_acc * scale + sext(bias)`.
  - Full precision: width `ACC_WIDTH+CDATA_SCALE_WIDTH+1`.
  - Signed multiply with no truncation.
- **S2, shift/round/saturate:**
  - `q = s2_val >>> shift` (arithmetic shift).
  - Round bit `r = s2_val[shift-1]` when `shift>0`, otherwise 0.
  - `y = q + r`, clamped to [-2^(IDATA_WIDTH-1), 2^(IDATA_WIDTH-1)-1].
  - Result is registered into `quant_odata` with `quant_odata_valid=1`.
- **Config isolation:** S1 and S2 use only the snapshot taken at group completion. A mid-pipeline `cfg_vld` does not affect in-flight results.
- **`busy`:** equals `(acc_cnt!=0) | s1_vld | s2_vld | quant_odata_valid`.
- **Back-pressure:** none. The downstream consumer must accept every pulse.

## Timing
- **Reset values:** `quant_odata=0`, `quant_odata_valid=0`, `busy=0`. Config resets to `acc_num=1`, `scale=1`, `bias=0`, `shift=0`. All pipeline valids and accumulators are 0.
- **Latency:** the final beat is sampled on edge N, and `quant_odata_valid` is high for exactly the cycle following edge N+2, i.e. 3 edges after the final beat.
- **`quant_odata` hold:** holds its last value while valid is low.
- **Throughput:** one group per cycle when `acc_num=1` and the input is valid every cycle. The pipeline is fully overlapped with no bubbles.
- **Input gaps:** allowed. Invalid cycles leave `acc`/`acc_cnt` unchanged.
- **`rst` mid-operation:** all state clears immediately. No output is produced for an interrupted group, and in-flight S1/S2 results are lost.
- **`cfg_vld` during a group:** partial sum is lost, and the first valid beat after it starts a fresh group under the new config.

## Test plan
- **Saturate high:** acc_num=32, scale=1, bias=0, shift=9; 32 beats of 4096 (acc=131072) -> one pulse, `quant_odata=127`, exactly 3 edges after beat 32.
- **Round half-up:** acc_num=4, shift=9, scale=1, bias=0.
  - Beats of 75 each (acc=300) -> `quant_odata=1`.
  - Beats of -75 each (acc=-300) -> `quant_odata=-1`.
  - Beats of -32768 each (acc=-131072) -> `quant_odata=-128`.
- **Scale and bias:** acc_num=1, shift=2.
  - `mac_odata=10`, scale=3, bias=0 (30) -> 8.
  - Same input with bias=-2 (28) -> 7.
- **Back-to-back:** acc_num=1, scale=1, shift=0; valid every cycle with values 1..20 -> 20 consecutive valid pulses carrying 1..20 in order, no gaps.
- **Config abort:** acc_num=8; after 5 beats, pulse `cfg_vld` with acc_num=2 while also driving a beat -> that beat is dropped, no output for the aborted group, and the next 2 beats produce one result of their sum.
- **Reset mid-flight:** assert `rst` 1 edge after a final beat -> no `quant_odata_valid` pulse appears, and `busy=0` immediately.
